// File: rtl/calc_addsub_unit.sv
// calc_addsub_unit: handshaked add/subtract core with accumulator and optional signed saturation
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid_i/in_ready_o   operand handshake (in_ready_o depends only on out_valid/out_ready)
//   a_i, b_i, op_i     operands and op (00 a+b, 01 a-b, 10 acc+a, 11 acc-a)
//   acc_clr_i          clears the accumulator on the edge, independent of the handshake
//   out_valid_o/out_ready_i  result handshake
//   result_o, cout_o, ovf_o  registered result, carry out of MSB, signed overflow of raw sum
//   acc_o              registered accumulator
module calc_addsub_unit #(
   parameter int WIDTH = 4,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       op_i,
   input  logic             acc_clr_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic [WIDTH-1:0] acc_o
);
   localparam int MSB = WIDTH - 1;
   logic             valid_q, valid_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d;
   logic             accept, sub, acc_op, ovf;
   logic [WIDTH-1:0] x, y, yp, sum, sat_val, res;
   logic [WIDTH:0]   raw;
   assign in_ready_o = !valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign sub        = op_i[0];
   assign acc_op     = op_i[1];
   // a clear in the same cycle as an accumulator op makes that op start from zero
   assign x       = acc_op ? (acc_clr_i ? '0 : acc_q) : a_i;
   assign y       = acc_op ? a_i : b_i;
   assign yp      = sub ? ~y : y;
   assign raw     = {1'b0, x} + {1'b0, yp} + {{WIDTH{1'b0}}, sub};
   assign sum     = raw[MSB:0];
   assign ovf     = (x[MSB] == yp[MSB]) && (sum[MSB] != x[MSB]);
   assign sat_val = x[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
   assign res     = (SAT != 0 && ovf) ? sat_val : sum;
   always_comb begin
      valid_d  = accept || (valid_q && !out_ready_i);
      result_d = accept ? res : result_q;
      cout_d   = accept ? raw[WIDTH] : cout_q;
      ovf_d    = accept ? ovf : ovf_q;
      acc_d    = (accept && acc_op) ? res : (acc_clr_i ? '0 : acc_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
      end
   end
   assign out_valid_o = valid_q;
   assign result_o    = result_q;
   assign cout_o      = cout_q;
   assign ovf_o       = ovf_q;
   assign acc_o       = acc_q;
endmodule
